// File: rtl/rv32i_branch_predictor_if.sv
// ============================================================================
// Module      : rv32i_branch_predictor_if
// Description : Signal bundle between fetch/MEM and the branch predictor.
//               master : pipeline side (drives lookup PC/instruction and
//                        MEM-stage resolution, receives prediction + stats)
//               slave  : predictor side
// Ports       : PC_IN, INST_IN                 lookup request
//               PRED_TAKEN_OUT, PRED_TARGET_OUT prediction
//               UPD_VALID_IN, UPD_PC_IN,
//               UPD_TAKEN_IN, UPD_MISPRED_IN    training from MEM
//               MISPRED_COUNT_OUT, BRANCH_COUNT_OUT statistics
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv32i_branch_predictor_if;
  logic [31:0] PC_IN;
  logic [31:0] INST_IN;
  logic        PRED_TAKEN_OUT;
  logic [31:0] PRED_TARGET_OUT;
  logic        UPD_VALID_IN;
  logic [31:0] UPD_PC_IN;
  logic        UPD_TAKEN_IN;
  logic        UPD_MISPRED_IN;
  logic [31:0] MISPRED_COUNT_OUT;
  logic [31:0] BRANCH_COUNT_OUT;

  modport master (
    output PC_IN, INST_IN, UPD_VALID_IN, UPD_PC_IN, UPD_TAKEN_IN, UPD_MISPRED_IN,
    input  PRED_TAKEN_OUT, PRED_TARGET_OUT, MISPRED_COUNT_OUT, BRANCH_COUNT_OUT
  );

  modport slave (
    input  PC_IN, INST_IN, UPD_VALID_IN, UPD_PC_IN, UPD_TAKEN_IN, UPD_MISPRED_IN,
    output PRED_TAKEN_OUT, PRED_TARGET_OUT, MISPRED_COUNT_OUT, BRANCH_COUNT_OUT
  );
endinterface

`default_nettype wire

// File: rtl/rv32i_branch_predictor.sv
// ============================================================================
// Module      : rv32i_branch_predictor
// Description : Dynamic branch predictor in front of RV32I fetch. Predecodes
//               the fetched word (B-type / JAL), looks up a table of 2-bit
//               saturating counters and supplies a zero-latency redirect.
//               MEM-stage resolutions train the table and the statistics.
// Ports       : clk  - pipeline clock (rising edge)
//               rst  - synchronous active-high reset
//               bp   - rv32i_branch_predictor_if.slave (lookup, prediction,
//                      training and statistics signals)
// Parameters  : IDX_W - counter-table index width (2^IDX_W entries, >= 2)
// Options     : GSHARE_EN - when defined, index = PC[IDX_W+1:2] XOR a global
//               history register fed by resolved outcomes; otherwise the
//               index is the PC bits alone (bimodal).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_branch_predictor #(
  parameter int IDX_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  rv32i_branch_predictor_if.slave bp
);

  localparam int         c_ENTRIES   = 1 << IDX_W;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  logic [1:0]       r_table [c_ENTRIES];
  logic [31:0]      r_branch_cnt;
  logic [31:0]      r_mispred_cnt;

  logic             w_is_branch;
  logic             w_is_jal;
  logic [31:0]      w_imm_b;
  logic [31:0]      w_imm_j;
  logic [31:0]      w_target;
  logic [IDX_W-1:0] w_lkp_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic [1:0]       w_lkp_ctr;
  logic [1:0]       w_upd_ctr;
  logic [1:0]       w_upd_next;
  logic             w_pred_taken;
  logic             w_unused_upd_pc;

  // Only the word-index bits of the resolved PC select a table entry.
  assign w_unused_upd_pc = ^{bp.UPD_PC_IN[31:IDX_W+2], bp.UPD_PC_IN[1:0]};

  // --------------------------------------------------------------------------
  // Predecode and target computation
  // --------------------------------------------------------------------------
  assign w_is_branch = (bp.INST_IN[6:0] == c_OP_BRANCH);
  assign w_is_jal    = (bp.INST_IN[6:0] == c_OP_JAL);

  assign w_imm_b = {{20{bp.INST_IN[31]}}, bp.INST_IN[7], bp.INST_IN[30:25],
                    bp.INST_IN[11:8], 1'b0};
  assign w_imm_j = {{12{bp.INST_IN[31]}}, bp.INST_IN[19:12], bp.INST_IN[20],
                    bp.INST_IN[30:21], 1'b0};

  // 32-bit add wraps silently past 0xFFFFFFFF.
  assign w_target = bp.PC_IN + (w_is_jal ? w_imm_j : w_imm_b);

  // --------------------------------------------------------------------------
  // Index generation
  // --------------------------------------------------------------------------
`ifdef GSHARE_EN
  logic [IDX_W-1:0] r_ghr;

  // The update index uses the history as it stood before this cycle's shift,
  // so a branch trains the same entry it was predicted from.
  assign w_lkp_idx = bp.PC_IN[IDX_W+1:2]     ^ r_ghr;
  assign w_upd_idx = bp.UPD_PC_IN[IDX_W+1:2] ^ r_ghr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (bp.UPD_VALID_IN) begin
      r_ghr <= {r_ghr[IDX_W-2:0], bp.UPD_TAKEN_IN};
    end
  end
`else
  assign w_lkp_idx = bp.PC_IN[IDX_W+1:2];
  assign w_upd_idx = bp.UPD_PC_IN[IDX_W+1:2];
`endif

  // --------------------------------------------------------------------------
  // Lookup (reads registered state only, so a same-cycle update is not seen)
  // --------------------------------------------------------------------------
  assign w_lkp_ctr    = r_table[w_lkp_idx];
  assign w_pred_taken = w_is_jal | (w_is_branch & w_lkp_ctr[1]);

  assign bp.PRED_TAKEN_OUT  = w_pred_taken;
  assign bp.PRED_TARGET_OUT = w_pred_taken ? w_target : (bp.PC_IN + 32'd4);

  // --------------------------------------------------------------------------
  // Saturating counter update
  // --------------------------------------------------------------------------
  assign w_upd_ctr = r_table[w_upd_idx];

  always_comb begin
    w_upd_next = w_upd_ctr;
    if (bp.UPD_TAKEN_IN) begin
      if (w_upd_ctr != 2'b11) begin
        w_upd_next = w_upd_ctr + 2'd1;
      end
    end else begin
      if (w_upd_ctr != 2'b00) begin
        w_upd_next = w_upd_ctr - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_ENTRIES; i++) begin
        r_table[i] <= 2'b01;
      end
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (bp.UPD_VALID_IN) begin
      r_table[w_upd_idx] <= w_upd_next;
      r_branch_cnt       <= r_branch_cnt + 32'd1;
      if (bp.UPD_MISPRED_IN) begin
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end

  assign bp.BRANCH_COUNT_OUT  = r_branch_cnt;
  assign bp.MISPRED_COUNT_OUT = r_mispred_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_branch_predictor.sv
// ============================================================================
// Module      : tb_rv32i_branch_predictor
// Description : Self-checking bench for rv32i_branch_predictor. Each stimulus
//               row pushes its expected prediction and statistics onto a
//               scoreboard; the value is popped and compared mid-cycle.
//               Expectations for the history-indexed variant follow the
//               GSHARE_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32i_branch_predictor;

  localparam logic [31:0] c_BEQ    = 32'h00208463; // beq x1,x2,+8
  localparam logic [31:0] c_BEQ_M4 = 32'hFE000EE3; // beq x0,x0,-4
  localparam logic [31:0] c_JAL_M8 = 32'hFF9FF06F; // jal x0,-8
  localparam logic [31:0] c_JAL_P8 = 32'h0080006F; // jal x0,+8
  localparam logic [31:0] c_JALR   = 32'h00008067; // jalr x0,0(x1)
  localparam logic [31:0] c_ADDI   = 32'h00000013; // nop

  typedef struct {
    string       nm;
    logic        r;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        um;
    logic        et;
    logic [31:0] etgt;
  } row_t;

  typedef struct {
    string       nm;
    logic        taken;
    logic [31:0] target;
    logic [31:0] br;
    logic [31:0] mis;
  } exp_t;

  logic clk;
  logic rst;
  rv32i_branch_predictor_if bif ();

  rv32i_branch_predictor #(.IDX_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bif)
  );

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_br   = 0;
  logic [31:0] m_mis  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of stimulus and queue what the DUT must show this cycle.
  task automatic step(input row_t s);
    @(posedge clk);
    #1;
    rst                = s.r;
    bif.PC_IN          = s.pc;
    bif.INST_IN        = s.inst;
    bif.UPD_VALID_IN   = s.uv;
    bif.UPD_PC_IN      = s.upc;
    bif.UPD_TAKEN_IN   = s.ut;
    bif.UPD_MISPRED_IN = s.um;
    sb.push_back('{s.nm, s.et, s.etgt, m_br, m_mis});
    if (s.r) begin
      m_br  = 0;
      m_mis = 0;
    end else if (s.uv) begin
      m_br = m_br + 1;
      if (s.um) m_mis = m_mis + 1;
    end
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back('{"rst_jal",      1'b1, 32'h200, c_JAL_M8, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h1F8});
    rows.push_back('{"rst_upd_drop", 1'b1, 32'h100, c_BEQ,    1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h104});
    rows.push_back('{"post_rst_beq", 1'b0, 32'h100, c_BEQ,    1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h104});
    foreach (rows[i]) begin
      step(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({bif.PRED_TAKEN_OUT, bif.PRED_TARGET_OUT, bif.BRANCH_COUNT_OUT, bif.MISPRED_COUNT_OUT}
          !== {e.taken, e.target, e.br, e.mis}) begin
        errors++;
        $display("FAIL %s: got taken=%0b target=%h br=%0d mis=%0d, expected taken=%0b target=%h br=%0d mis=%0d",
                 e.nm, bif.PRED_TAKEN_OUT, bif.PRED_TARGET_OUT, bif.BRANCH_COUNT_OUT,
                 bif.MISPRED_COUNT_OUT, e.taken, e.target, e.br, e.mis);
      end
    end
  endtask

  task automatic test_training();
    row_t rows[$];
    exp_t e;
    rows.push_back('{"tr_t1_ctr01", 1'b0, 32'h100, c_BEQ, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h104});
    rows.push_back('{"tr_t2_ctr10", 1'b0, 32'h100, c_BEQ, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h108});
    rows.push_back('{"tr_t3_ctr11", 1'b0, 32'h100, c_BEQ, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h108});
    rows.push_back('{"tr_sat_hi",   1'b0, 32'h100, c_BEQ, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h108});
    rows.push_back('{"tr_n2_ctr10", 1'b0, 32'h100, c_BEQ, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h108});
    rows.push_back('{"tr_n3_ctr01", 1'b0, 32'h100, c_BEQ, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h104});
    rows.push_back('{"tr_n4_ctr00", 1'b0, 32'h100, c_BEQ, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h104});
    rows.push_back('{"tr_sat_lo",   1'b0, 32'h100, c_BEQ, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h104});
    rows.push_back('{"tr_t_ctr01",  1'b0, 32'h100, c_BEQ, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h104});
    rows.push_back('{"tr_ctr10",    1'b0, 32'h100, c_BEQ, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h108});
    foreach (rows[i]) begin
      step(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({bif.PRED_TAKEN_OUT, bif.PRED_TARGET_OUT, bif.BRANCH_COUNT_OUT, bif.MISPRED_COUNT_OUT}
          !== {e.taken, e.target, e.br, e.mis}) begin
        errors++;
        $display("FAIL %s: got taken=%0b target=%h br=%0d mis=%0d, expected taken=%0b target=%h br=%0d mis=%0d",
                 e.nm, bif.PRED_TAKEN_OUT, bif.PRED_TARGET_OUT, bif.BRANCH_COUNT_OUT,
                 bif.MISPRED_COUNT_OUT, e.taken, e.target, e.br, e.mis);
      end
    end
  endtask

  // Entry for PC 0x100 is weak-taken here; entry for 0x104 is still weak-NT.
  task automatic test_decode();
    row_t rows[$];
    exp_t e;
    rows.push_back('{"jal_back",     1'b0, 32'h200,      c_JAL_M8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1F8});
    rows.push_back('{"jalr_nopred",  1'b0, 32'h200,      c_JALR,   1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h204});
    rows.push_back('{"addi_nopred",  1'b0, 32'h200,      c_ADDI,   1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h204});
    rows.push_back('{"jal_wrap",     1'b0, 32'hFFFFFFFC, c_JAL_P8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h4});
    rows.push_back('{"seq_wrap",     1'b0, 32'hFFFFFFFC, c_JALR,   1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
    rows.push_back('{"beq_neg_imm",  1'b0, 32'h100,      c_BEQ_M4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFC});
    rows.push_back('{"beq_other_nt", 1'b0, 32'h104,      c_BEQ_M4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h108});
    foreach (rows[i]) begin
      step(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({bif.PRED_TAKEN_OUT, bif.PRED_TARGET_OUT, bif.BRANCH_COUNT_OUT, bif.MISPRED_COUNT_OUT}
          !== {e.taken, e.target, e.br, e.mis}) begin
        errors++;
        $display("FAIL %s: got taken=%0b target=%h br=%0d mis=%0d, expected taken=%0b target=%h br=%0d mis=%0d",
                 e.nm, bif.PRED_TAKEN_OUT, bif.PRED_TARGET_OUT, bif.BRANCH_COUNT_OUT,
                 bif.MISPRED_COUNT_OUT, e.taken, e.target, e.br, e.mis);
      end
    end
  endtask

  task automatic test_same_cycle();
    row_t rows[$];
    exp_t e;
    rows.push_back('{"sc_reset",     1'b1, 32'h400, c_ADDI, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h404});
    rows.push_back('{"sc_pre_upd",   1'b0, 32'h100, c_BEQ,  1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h104});
    rows.push_back('{"sc_post_upd",  1'b0, 32'h100, c_BEQ,  1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h108});
    foreach (rows[i]) begin
      step(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({bif.PRED_TAKEN_OUT, bif.PRED_TARGET_OUT, bif.BRANCH_COUNT_OUT, bif.MISPRED_COUNT_OUT}
          !== {e.taken, e.target, e.br, e.mis}) begin
        errors++;
        $display("FAIL %s: got taken=%0b target=%h br=%0d mis=%0d, expected taken=%0b target=%h br=%0d mis=%0d",
                 e.nm, bif.PRED_TAKEN_OUT, bif.PRED_TARGET_OUT, bif.BRANCH_COUNT_OUT,
                 bif.MISPRED_COUNT_OUT, e.taken, e.target, e.br, e.mis);
      end
    end
  endtask

  // Five resolutions (two mispredicted), one stray mispredict flag without
  // valid, then a reset in the middle of activity.
  task automatic test_stats_and_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back('{"st_reset",      1'b1, 32'h100, c_BEQ, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h108});
    rows.push_back('{"st_u1",         1'b0, 32'h100, c_BEQ, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h104});
    rows.push_back('{"st_u2",         1'b0, 32'h100, c_BEQ, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h108});
    rows.push_back('{"st_u3",         1'b0, 32'h100, c_BEQ, 1'b1, 32'h304, 1'b1, 1'b1, 1'b1, 32'h108});
    rows.push_back('{"st_u4",         1'b0, 32'h100, c_BEQ, 1'b1, 32'h304, 1'b0, 1'b0, 1'b1, 32'h108});
    rows.push_back('{"st_u5",         1'b0, 32'h100, c_BEQ, 1'b1, 32'h304, 1'b0, 1'b0, 1'b1, 32'h108});
    rows.push_back('{"st_stray_mis",  1'b0, 32'h100, c_BEQ, 1'b0, 32'h100, 1'b0, 1'b1, 1'b1, 32'h108});
    rows.push_back('{"st_totals",     1'b0, 32'h100, c_BEQ, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h108});
    rows.push_back('{"st_mid_reset",  1'b1, 32'h100, c_BEQ, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 32'h108});
    rows.push_back('{"st_after_rst",  1'b0, 32'h100, c_BEQ, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h104});
    foreach (rows[i]) begin
      step(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({bif.PRED_TAKEN_OUT, bif.PRED_TARGET_OUT, bif.BRANCH_COUNT_OUT, bif.MISPRED_COUNT_OUT}
          !== {e.taken, e.target, e.br, e.mis}) begin
        errors++;
        $display("FAIL %s: got taken=%0b target=%h br=%0d mis=%0d, expected taken=%0b target=%h br=%0d mis=%0d",
                 e.nm, bif.PRED_TAKEN_OUT, bif.PRED_TARGET_OUT, bif.BRANCH_COUNT_OUT,
                 bif.MISPRED_COUNT_OUT, e.taken, e.target, e.br, e.mis);
      end
    end
  endtask

  // One taken resolution of PC 0x100 trains entry 0 (history was 0). With
  // history 000001, PC 0x104 then maps to entry 0 and PC 0x100 to entry 1.
  task automatic test_index();
    row_t rows[$];
    exp_t e;
    rows.push_back('{"ix_reset", 1'b1, 32'h100, c_BEQ, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h104});
    rows.push_back('{"ix_train", 1'b0, 32'h100, c_BEQ, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h104});
`ifdef GSHARE_EN
    rows.push_back('{"ix_pc104", 1'b0, 32'h104, c_BEQ, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h10C});
    rows.push_back('{"ix_pc100", 1'b0, 32'h100, c_BEQ, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h104});
`else
    rows.push_back('{"ix_pc104", 1'b0, 32'h104, c_BEQ, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h108});
    rows.push_back('{"ix_pc100", 1'b0, 32'h100, c_BEQ, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h108});
`endif
    foreach (rows[i]) begin
      step(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({bif.PRED_TAKEN_OUT, bif.PRED_TARGET_OUT, bif.BRANCH_COUNT_OUT, bif.MISPRED_COUNT_OUT}
          !== {e.taken, e.target, e.br, e.mis}) begin
        errors++;
        $display("FAIL %s: got taken=%0b target=%h br=%0d mis=%0d, expected taken=%0b target=%h br=%0d mis=%0d",
                 e.nm, bif.PRED_TAKEN_OUT, bif.PRED_TARGET_OUT, bif.BRANCH_COUNT_OUT,
                 bif.MISPRED_COUNT_OUT, e.taken, e.target, e.br, e.mis);
      end
    end
  endtask

  initial begin
    rst                = 1'b1;
    bif.PC_IN          = 32'h0;
    bif.INST_IN        = c_ADDI;
    bif.UPD_VALID_IN   = 1'b0;
    bif.UPD_PC_IN      = 32'h0;
    bif.UPD_TAKEN_IN   = 1'b0;
    bif.UPD_MISPRED_IN = 1'b0;

    test_reset();
    test_training();
    test_decode();
    test_same_cycle();
    test_stats_and_reset();
    test_index();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
